uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 460800, line bit rate in bit/s.
REQ-003 clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 data  output  8  last correctly received byte.
REQ-007 valid  output  1  one-cycle pulse; data is new and stable.
REQ-008 frame_err  output  1  one-cycle pulse; stop bit (or parity, see REQ-025) failed.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 rx SHALL pass a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 Bit period DIV SHALL be (CLK_FREQ + BAUD/2) / BAUD in integer arithmetic (109 at defaults); HALF = DIV/2 (54).
REQ-012 Frame SHALL be 8N1: start 0, data LSB first, stop 1.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: a high-to-low transition on rx_s SHALL enter START and clear the baud counter.
REQ-015 START: after HALF cycles rx_s SHALL be sampled; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: rx_s SHALL be sampled every DIV cycles into bit index 0..7; after the sample at index 7 -> STOP.
REQ-017 STOP: rx_s SHALL be sampled after DIV cycles; 1 -> data updated, valid pulsed on the next clock, -> IDLE; 0 -> frame_err pulsed on the next clock, data unchanged, -> WAIT_IDLE.
REQ-018 WAIT_IDLE: SHALL remain until rx_s = 1, then -> IDLE (line break produces exactly one frame_err).
REQ-019 valid and frame_err SHALL never be asserted in the same cycle and SHALL be at most one cycle wide.
REQ-020 data SHALL hold its value between valid pulses; the shift register is internal.
REQ-021 Baud counter width SHALL be $clog2(DIV) bits; the counter SHALL never wrap past DIV-1.
REQ-022 A start edge arriving in the same cycle as the transition out of STOP SHALL be detected in IDLE on the following cycle (back-to-back frames with one stop bit are received without loss).

Reset
REQ-023 Reset SHALL force state IDLE, data = 8'h00, valid = 0, frame_err = 0, busy = 0, synchronizer flops = 1, counters = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no valid/frame_err pulse; reception resumes at the next start edge after release.

Configuration
REQ-025 With UART_RX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP, one even-parity bit is sampled DIV cycles after bit 7, and a parity mismatch produces frame_err (data unchanged, next state per REQ-017 with stop sampled normally). Without it the frame is strictly 8N1 and no PARITY state exists.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state enum and the frame constants (data bit count 8, idle level 1).
REQ-027 One sub-module, uart_baud_cnt (counter with clear input and tick output at the programmed count), SHALL be instantiated; the synchronizer stays inline.

Verification (defaults CLK_FREQ = 50 MHz, BAUD = 460800; stimulus from the team's uart_tx model)
REQ-028 Send 8'hA5 -> exactly one valid pulse, data = 8'hA5, frame_err never set, busy low afterwards.
REQ-029 Send 8'h00, 8'hFF, 8'h55 back-to-back, 1 stop bit each -> three valid pulses with data 00, FF, 55 in order.
REQ-030 40-cycle low glitch on idle rx -> busy pulses high then low, no valid, no frame_err.
REQ-031 Frame 8'h3C with stop bit forced 0, line held low a further 2000 cycles -> one frame_err, no valid, data keeps its previous value, busy until rx returns high.
REQ-032 rst_n pulsed low during data bit 4 of 8'hC3, then send 8'h81 -> no pulse for the aborted frame; valid with data = 8'h81.
REQ-033 (UART_RX_PARITY_EN) 8'h07 with parity 1 -> valid, data = 8'h07; same byte with parity 0 -> frame_err only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and 8N1 frame constants.
// Optional macro UART_RX_PARITY_EN adds an even-parity state to the encoding.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud counter: counts from 0 up to the programmed limit, ticks on the limit
// cycle and restarts at 0, so it never runs past the limit.
module uart_baud_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == limit);

  // Next count: restart on clear, on the tick, or if the limit dropped below the count
  always_comb begin
    cnt_d = cnt_q;
    if (clr || cnt_q >= limit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, oversampling-free mid-bit sampling with a shared baud counter.
// Define UART_RX_PARITY_EN to receive one even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 460800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  // Synchronizer and edge-detect history
  logic sync1_q, sync2_q, rx_prev_q;
  logic rx_s;

  rx_state_e state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       busy_q, busy_d;
  logic       stop_ok;

  logic          cnt_clr;
  logic          tick;
  logic [CW-1:0] cnt_limit;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
`endif

  assign rx_s = sync2_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= IDLE_LEVEL;
      sync2_q   <= IDLE_LEVEL;
      rx_prev_q <= IDLE_LEVEL;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // Half a bit to reach mid-start, then full bit periods between samples
  assign cnt_limit = (state_q == ST_START) ? CW'(HALF - 1) : CW'(DIV - 1);

  uart_baud_cnt #(
    .W(CW)
  ) u_baud_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .limit(cnt_limit),
    .tick (tick)
  );

`ifdef UART_RX_PARITY_EN
  assign stop_ok = rx_s && !par_err_q;
`else
  assign stop_ok = rx_s;
`endif

  // Next-state and output logic. rx_prev_q tracks rx_s every cycle, so a start
  // edge right as STOP exits is still seen as an edge in the first IDLE cycle.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    cnt_clr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_prev_q && !rx_s) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            par_err_d = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          // Even parity: data bits plus parity bit must hold an even count of ones
          par_err_d = (^shift_q) ^ rx_s;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (stop_ok) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_s == IDLE_LEVEL) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM and registered output state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule
